command_stream_encoder: RTL and testbench

- Builds the command word stream that feeds the rasterizer command input (s_cmd_axis of the command parser), so command traffic can be generated on-chip instead of only by the host DMA.
- Accepts one high-level request at a time: NOP, framebuffer op, render-config write, triangle stream or texture stream.
- For each request it emits a header word, then either one config data word or a forwarded payload stream.
- Opcode values and field positions come from the shared RegisterAndDescriptorDefines header: OP_*, *_POS, *_SIZE, OP_TEXTURE_STREAM_MODE_*.

---
 rtl/command_stream_encoder.sv | 239 +++++++++++++++++++++++
 tb/tb_command_stream_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_stream_encoder.sv
// Command stream encoder: turns one high-level request at a time into
// rasterizer command words. Each request produces a header word, followed by
// either one config data word or a forwarded payload stream. The output goes
// through a single AXI-Stream register that allows back-to-back words.
module command_stream_encoder #(
  parameter int unsigned CMD_STREAM_WIDTH = 32,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_op,
  input  logic [3:0]                  req_fb_flags,
  input  logic [3:0]                  req_cfg_index,
  input  logic [15:0]                 req_cfg_data,
  input  logic [11:0]                 req_tri_words,
  input  logic [3:0]                  req_tex_size,
  input  logic [3:0]                  req_tex_mode,
  input  logic                        s_payload_axis_tvalid,
  output logic                        s_payload_axis_tready,
  input  logic                        s_payload_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_payload_axis_tdata,
  output logic                        m_cmd_axis_tvalid,
  input  logic                        m_cmd_axis_tready,
  output logic                        m_cmd_axis_tlast,
  output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
  output logic                        busy,
  output logic                        err_len
);

  // Command word layout shared with the command parser.
  localparam int unsigned OP_POS                       = 28;
  localparam int unsigned OP_SIZE                      = 4;
  localparam int unsigned OP_IMM_SIZE                  = 24;
  localparam logic [3:0]  OP_NOP_STREAM                = 4'h0;
  localparam logic [3:0]  OP_RENDER_CONFIG             = 4'h1;
  localparam logic [3:0]  OP_FRAMEBUFFER               = 4'h2;
  localparam logic [3:0]  OP_TRIANGLE_STREAM           = 4'h3;
  localparam logic [3:0]  OP_TEXTURE_STREAM            = 4'h5;
  localparam int unsigned OP_FRAMEBUFFER_COMMIT_POS    = 0;
  localparam int unsigned OP_FRAMEBUFFER_MEMSET_POS    = 1;
  localparam int unsigned OP_FRAMEBUFFER_COLOR_SEL_POS = 4;
  localparam int unsigned OP_FRAMEBUFFER_DEPTH_SEL_POS = 5;
  localparam int unsigned TEXTURE_STREAM_SIZE_POS      = 0;
  localparam int unsigned TEXTURE_STREAM_MODE_POS      = 16;
  localparam logic [3:0]  TEX_SIZE_32                  = 4'd1;
  localparam logic [3:0]  TEX_SIZE_64                  = 4'd2;
  localparam logic [3:0]  TEX_SIZE_128                 = 4'd3;
  localparam logic [3:0]  TEX_SIZE_256                 = 4'd4;

  // Request opcodes on req_op.
  localparam logic [2:0] REQ_NOP      = 3'd0;
  localparam logic [2:0] REQ_FB       = 3'd1;
  localparam logic [2:0] REQ_CFG      = 3'd2;
  localparam logic [2:0] REQ_TRIANGLE = 3'd3;
  localparam logic [2:0] REQ_TEXTURE  = 3'd4;

  typedef enum logic [1:0] {StIdle, StHeader, StCfgData, StPayload} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  op_q;
  logic [3:0]                  fb_flags_q;
  logic [3:0]                  cfg_index_q;
  logic [15:0]                 cfg_data_q;
  logic [11:0]                 tri_words_q;
  logic [3:0]                  tex_size_q;
  logic [3:0]                  tex_mode_q;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [CMD_STREAM_WIDTH-1:0] out_data_q, out_data_d;
  logic                        err_len_q, err_len_d;

  logic                        out_free;
  logic                        req_fire;
  logic                        beat;
  logic                        cnt_is_one;
  logic [CNT_WIDTH-1:0]        tex_words;
  logic [CMD_STREAM_WIDTH-1:0] header;
  logic                        header_last;

  // Output register can take a new word when empty or drained this cycle.
  assign out_free   = !out_valid_q || m_cmd_axis_tready;
  // Outputs that are combinational on state are forced low while reset is held.
  assign req_ready  = resetn && (state_q == StIdle) && !out_valid_q;
  assign req_fire   = req_valid && req_ready;
  assign s_payload_axis_tready = resetn && (state_q == StPayload) && out_free;
  assign beat       = s_payload_axis_tvalid && s_payload_axis_tready;
  assign cnt_is_one = (cnt_q == CNT_WIDTH'(1));

  assign m_cmd_axis_tvalid = out_valid_q;
  assign m_cmd_axis_tlast  = out_last_q;
  assign m_cmd_axis_tdata  = out_data_q;
  assign busy              = (state_q != StIdle);
  assign err_len           = err_len_q;

  // Texture payload length in words (two texels per word); 0 for unknown codes.
  always_comb begin
    tex_words = '0;
    case (tex_size_q)
      TEX_SIZE_32:  tex_words = CNT_WIDTH'(512);
      TEX_SIZE_64:  tex_words = CNT_WIDTH'(2048);
      TEX_SIZE_128: tex_words = CNT_WIDTH'(8192);
      TEX_SIZE_256: tex_words = CNT_WIDTH'(32768);
      default:      tex_words = '0;
    endcase
  end

  // Header word and whether it ends the command.
  always_comb begin
    header      = '0;
    header_last = 1'b1;
    case (op_q)
      REQ_FB: begin
        header[OP_POS +: OP_SIZE]            = OP_FRAMEBUFFER;
        header[OP_FRAMEBUFFER_COMMIT_POS]    = fb_flags_q[0];
        header[OP_FRAMEBUFFER_MEMSET_POS]    = fb_flags_q[1];
        header[OP_FRAMEBUFFER_COLOR_SEL_POS] = fb_flags_q[2];
        header[OP_FRAMEBUFFER_DEPTH_SEL_POS] = fb_flags_q[3];
      end
      REQ_CFG: begin
        header[OP_POS +: OP_SIZE] = OP_RENDER_CONFIG;
        header[3:0]               = cfg_index_q;
        header_last               = 1'b0;
      end
      REQ_TRIANGLE: begin
        header[OP_POS +: OP_SIZE] = OP_TRIANGLE_STREAM;
        header[0 +: OP_IMM_SIZE]  = OP_IMM_SIZE'({tri_words_q, 2'b00});
        header_last               = (tri_words_q == '0);
      end
      REQ_TEXTURE: begin
        header[OP_POS +: OP_SIZE]              = OP_TEXTURE_STREAM;
        header[TEXTURE_STREAM_MODE_POS +: 4]   = tex_mode_q;
        header[TEXTURE_STREAM_SIZE_POS +: 4]   = tex_size_q;
        header_last                            = (tex_words == '0);
      end
      default: header[OP_POS +: OP_SIZE] = OP_NOP_STREAM;
    endcase
  end

  // Next-state, output register and error flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !m_cmd_axis_tready;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    err_len_d   = err_len_q;
    unique case (state_q)
      StIdle: begin
        // Reserved opcodes are accepted and dropped.
        if (req_fire && (req_op <= REQ_TEXTURE)) state_d = StHeader;
      end
      StHeader: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = header;
          out_last_d  = header_last;
          state_d     = StIdle;
          if (op_q == REQ_CFG) begin
            state_d = StCfgData;
          end else if ((op_q == REQ_TRIANGLE) && (tri_words_q != '0)) begin
            cnt_d   = CNT_WIDTH'(tri_words_q);
            state_d = StPayload;
          end else if (op_q == REQ_TEXTURE) begin
            if (tex_words != '0) begin
              cnt_d   = tex_words;
              state_d = StPayload;
            end else if (tex_size_q != '0) begin
              err_len_d = 1'b1;
            end
          end
        end
      end
      StCfgData: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = {{(CMD_STREAM_WIDTH - 16){1'b0}}, cfg_data_q};
          out_last_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      StPayload: begin
        // Our counter, not the source tlast, decides where the command ends.
        if (beat) begin
          out_valid_d = 1'b1;
          out_data_d  = s_payload_axis_tdata;
          out_last_d  = cnt_is_one;
          cnt_d       = cnt_q - CNT_WIDTH'(1);
          if (s_payload_axis_tlast != cnt_is_one) err_len_d = 1'b1;
          if (cnt_is_one) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, output register and error flag with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      err_len_q   <= err_len_d;
    end
  end

  // Request fields captured on acceptance.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      op_q        <= '0;
      fb_flags_q  <= '0;
      cfg_index_q <= '0;
      cfg_data_q  <= '0;
      tri_words_q <= '0;
      tex_size_q  <= '0;
      tex_mode_q  <= '0;
    end else if (req_fire) begin
      op_q        <= req_op;
      fb_flags_q  <= req_fb_flags;
      cfg_index_q <= req_cfg_index;
      cfg_data_q  <= req_cfg_data;
      tri_words_q <= req_tri_words;
      tex_size_q  <= req_tex_size;
      tex_mode_q  <= req_tex_mode;
    end
  end

endmodule

// File: tb/tb_command_stream_encoder.sv
// Scoreboard bench for command_stream_encoder: stimulus pushes expected
// command words into a queue, a negedge monitor pops and compares them on
// every output handshake and checks that stalled words stay stable.
module tb_command_stream_encoder;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [3:0]  req_fb_flags = '0;
  logic [3:0]  req_cfg_index = '0;
  logic [15:0] req_cfg_data = '0;
  logic [11:0] req_tri_words = '0;
  logic [3:0]  req_tex_size = '0;
  logic [3:0]  req_tex_mode = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic        busy;
  logic        err_len;

  command_stream_encoder #(
    .CMD_STREAM_WIDTH(32),
    .CNT_WIDTH       (16)
  ) dut (
    .aclk                 (aclk),
    .resetn               (resetn),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_op               (req_op),
    .req_fb_flags         (req_fb_flags),
    .req_cfg_index        (req_cfg_index),
    .req_cfg_data         (req_cfg_data),
    .req_tri_words        (req_tri_words),
    .req_tex_size         (req_tex_size),
    .req_tex_mode         (req_tex_mode),
    .s_payload_axis_tvalid(s_tvalid),
    .s_payload_axis_tready(s_tready),
    .s_payload_axis_tlast (s_tlast),
    .s_payload_axis_tdata (s_tdata),
    .m_cmd_axis_tvalid    (m_tvalid),
    .m_cmd_axis_tready    (m_tready),
    .m_cmd_axis_tlast     (m_tlast),
    .m_cmd_axis_tdata     (m_tdata),
    .busy                 (busy),
    .err_len              (err_len)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int passes = 0;

  logic [32:0] exp_q[$];
  logic        sb_en = 1'b1;
  int          words_seen = 0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = !m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pop on handshake, check stability while stalled.
  logic        hold_v = 1'b0;
  logic [32:0] hold_w;
  always @(negedge aclk) begin
    logic [32:0] w;
    if (resetn && sb_en) begin
      if (hold_v) chk("hold_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, hold_w});
      if (m_tvalid && m_tready) begin
        words_seen++;
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h last %b expected none", m_tdata, m_tlast);
        end else begin
          w = exp_q.pop_front();
          chk("cmd_word", {m_tlast, m_tdata}, w);
        end
      end else if (m_tvalid) begin
        hold_v = 1'b1;
        hold_w = {m_tlast, m_tdata};
      end else begin
        hold_v = 1'b0;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] flags, input logic [3:0] idx,
                       input logic [15:0] data, input logic [11:0] tw, input logic [3:0] ts,
                       input logic [3:0] tm);
    int n;
    @(posedge aclk); #1;
    req_op = op; req_fb_flags = flags; req_cfg_index = idx; req_cfg_data = data;
    req_tri_words = tw; req_tex_size = ts; req_tex_mode = tm;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++;
      $display("FAIL req_accept_timeout: got req_ready 0 expected 1");
    end
    @(posedge aclk); #1;
    req_valid = 1'b0;
  endtask

  // Drive n payload beats base+i; source tlast on beat number last_at (1-based, 0 = never).
  task automatic send_payload(input int n, input logic [31:0] base, input int last_at);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < n * 4 + 200) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      s_tlast  = (i + 1 == last_at);
      @(negedge aclk);
      if (s_tready) i++;
      @(posedge aclk); #1;
      cyc++;
    end
    if (i < n) begin
      checks++;
      $display("FAIL payload_timeout: got %0d beats expected %0d", i, n);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic push_payload(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 32'(i)});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((busy || m_tvalid || exp_q.size() != 0) && n < 2000);
    chk(name, {busy, m_tvalid, 32'(exp_q.size())}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    int rdy_seen;
    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_outputs", {req_ready, s_tready, m_tvalid, m_tlast, m_tdata, busy, err_len}, 64'd0);
    @(posedge aclk); #1;
    resetn = 1'b1;
    @(negedge aclk);
    chk("idle_after_reset", {req_ready, busy}, {1'b1, 1'b0});

    // Render-config write
    rdy_mode = 0;
    exp_q.push_back({1'b0, 32'h1000_0003});
    exp_q.push_back({1'b1, 32'h0000_ABCD});
    issue(3'd2, 4'h0, 4'd3, 16'hABCD, 12'd0, 4'd0, 4'd0);
    wait_idle("cfg_drain");

    // Triangle, 12 words, downstream ready toggling
    rdy_mode = 1;
    exp_q.push_back({1'b0, 32'h3000_0030});
    push_payload(12, 32'hA5A5_0100);
    issue(3'd3, 4'h0, 4'd0, 16'h0, 12'd12, 4'd0, 4'd0);
    send_payload(12, 32'hA5A5_0100, 12);
    wait_idle("tri_drain");

    // Texture 32x32, mode 2: header + 512 beats
    rdy_mode = 0;
    seen0 = words_seen;
    exp_q.push_back({1'b0, 32'h5002_0001});
    push_payload(512, 32'h1234_0000);
    issue(3'd4, 4'h0, 4'd0, 16'h0, 12'd0, 4'd1, 4'd2);
    send_payload(512, 32'h1234_0000, 512);
    wait_idle("tex_drain");
    chk("tex_word_count", 64'(words_seen - seen0), 64'd513);

    // Texture size 0: single header, no payload accepted
    exp_q.push_back({1'b1, 32'h5000_0000});
    issue(3'd4, 4'h0, 4'd0, 16'h0, 12'd0, 4'd0, 4'd0);
    s_tvalid = 1'b1;
    rdy_seen = 0;
    repeat (10) begin
      @(negedge aclk);
      if (s_tready) rdy_seen++;
    end
    s_tvalid = 1'b0;
    chk("tex0_no_payload", 64'(rdy_seen), 64'd0);
    wait_idle("tex0_drain");

    // Framebuffer flags {depth,color,memset,commit} = 1101, then NOP
    exp_q.push_back({1'b1, 32'h2000_0031});
    issue(3'd1, 4'b1101, 4'd0, 16'h0, 12'd0, 4'd0, 4'd0);
    exp_q.push_back({1'b1, 32'h0000_0000});
    issue(3'd0, 4'h0, 4'd0, 16'h0, 12'd0, 4'd0, 4'd0);
    wait_idle("fb_nop_drain");

    // Reserved opcode is dropped
    issue(3'd6, 4'hF, 4'hF, 16'hFFFF, 12'hFFF, 4'hF, 4'hF);
    repeat (3) @(negedge aclk);
    chk("reserved_dropped", {busy, m_tvalid}, 64'd0);
    chk("err_len_clean", 64'(err_len), 64'd0);

    // Undefined texture size code: header only, err_len set
    exp_q.push_back({1'b1, 32'h5003_0007});
    issue(3'd4, 4'h0, 4'd0, 16'h0, 12'd0, 4'd7, 4'd3);
    wait_idle("tex_bad_drain");
    chk("err_len_bad_size", 64'(err_len), 64'd1);

    // Reset clears the sticky error
    @(posedge aclk); #1;
    resetn = 1'b0;
    @(posedge aclk); #1;
    resetn = 1'b1;
    @(negedge aclk);
    chk("err_len_reset", 64'(err_len), 64'd0);

    // Early source tlast on beat 5: all 12 beats still forwarded
    rdy_mode = 2;
    exp_q.push_back({1'b0, 32'h3000_0030});
    push_payload(12, 32'hBEEF_0000);
    issue(3'd3, 4'h0, 4'd0, 16'h0, 12'd12, 4'd0, 4'd0);
    send_payload(12, 32'hBEEF_0000, 5);
    wait_idle("tri_err_drain");
    chk("err_len_early_tlast", 64'(err_len), 64'd1);

    // Reset in the middle of a payload
    rdy_mode = 0;
    sb_en = 1'b0;
    issue(3'd3, 4'h0, 4'd0, 16'h0, 12'd12, 4'd0, 4'd0);
    send_payload(6, 32'hCAFE_0000, 0);
    resetn = 1'b0;
    @(posedge aclk); #1;
    chk("midreset_outputs", {m_tvalid, busy, s_tready, err_len}, 64'd0);
    resetn = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    exp_q.push_back({1'b1, 32'h0000_0000});
    issue(3'd0, 4'h0, 4'd0, 16'h0, 12'd0, 4'd0, 4'd0);
    wait_idle("post_reset_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
